// File: rtl/bar_frame_gen.sv
// Bar-graph frame generator for the LED matrix: double-buffered per-column levels,
// one full frame of pixel writes per start, then a flip/acknowledge handshake.
module bar_frame_gen #(
  parameter int COLS = 16,
  parameter int ROWS = 8,
  parameter int XW   = 4,
  parameter int YW   = 3,
  parameter int LW   = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lvl_we,
  input  logic [XW-1:0] lvl_col,
  input  logic [LW-1:0] lvl_val,
  input  logic [1:0]    mode,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          valid,
  output logic          flip,
  input  logic          flipped
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    RENDER,
    FLIP,
    WAIT_FLIP
  } state_t;

  state_t state, state_d;

  logic [LW-1:0] pending [COLS];
  logic [LW-1:0] active  [COLS];
  logic [LW-1:0] snap    [COLS];
  logic [1:0]    mode_q;

  logic          wr_ok;
  logic [LW-1:0] wr_val;

  logic          last_col, last_row;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [LW-1:0] nxt_lvl;

  logic          load;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [3*CW-1:0] rgb_d;
  logic          valid_d, flip_d, done_d;

  // Colour of one pixel given its column level, row and render mode ({red, green, blue}).
  function automatic logic [3*CW-1:0] shade(input logic [LW-1:0] lvl,
                                            input logic [YW-1:0] row,
                                            input logic [1:0]    m);
    int l;
    int r;
    l = int'(lvl);
    r = int'(row);
    shade = '0;
    if (m == 2'd1) begin
      if (l > 0 && r == l - 1) shade = {CMAX, CMAX, CMAX};
    end else if (r < l) begin
      if (r < ROWS / 2)          shade = {CZERO, CMAX, CZERO};
      else if (r < 3 * ROWS / 4) shade = {CMAX, CMAX, CZERO};
      else                       shade = {CMAX, CZERO, CZERO};
    end
  endfunction

  assign wr_ok  = lvl_we && (int'(lvl_col) < COLS);
  assign wr_val = (lvl_val > LW'(ROWS)) ? LW'(ROWS) : lvl_val;

  // Pending levels as they will be after this edge; also the snapshot taken on start,
  // so a write coinciding with start is included in that frame.
  always_comb begin
    for (int i = 0; i < COLS; i++) begin
      snap[i] = pending[i];
      if (wr_ok && int'(lvl_col) == i) snap[i] = wr_val;
    end
  end

  // NOTE: the level registers are plain flops with a reset, not a RAM; a cleared bar
  // state after reset is part of the block's contract, so every entry is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) pending[i] <= '0;
    end else begin
      for (int i = 0; i < COLS; i++) pending[i] <= snap[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) active[i] <= '0;
      mode_q <= 2'd0;
    end else if (load) begin
      for (int i = 0; i < COLS; i++) active[i] <= snap[i];
      mode_q <= mode;
    end
  end

  // Scan position of the next pixel, derived from the registered x/y outputs.
  assign last_col = (x == XW'(COLS - 1));
  assign last_row = (y == YW'(ROWS - 1));
  assign nx       = last_col ? '0 : x + XW'(1);
  assign ny       = last_col ? y + YW'(1) : y;

  always_comb begin
    nxt_lvl = '0;
    for (int i = 0; i < COLS; i++) begin
      if (int'(nx) == i) nxt_lvl = active[i];
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    rgb_d   = '0;
    valid_d = 1'b0;
    flip_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = RENDER;
          load    = 1'b1;
          valid_d = 1'b1;
          rgb_d   = shade(snap[0], '0, mode);
        end
      end
      RENDER: begin
        if (last_col && last_row) begin
          state_d = FLIP;
          flip_d  = 1'b1;
        end else begin
          x_d     = nx;
          y_d     = ny;
          valid_d = 1'b1;
          rgb_d   = shade(nxt_lvl, ny, mode_q);
        end
      end
      FLIP: begin
        state_d = WAIT_FLIP;
      end
      WAIT_FLIP: begin
        if (flipped) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      valid      <= 1'b0;
      flip       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state               <= state_d;
      x                   <= x_d;
      y                   <= y_d;
      {red, green, blue}  <= rgb_d;
      valid               <= valid_d;
      flip                <= flip_d;
      frame_done          <= done_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bar_frame_gen.sv
// Scoreboard bench for bar_frame_gen: stimulus pushes the expected frame computed from
// the bar rules; a negedge monitor pops and compares every pixel and flip.
module tb_bar_frame_gen;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int XW   = 5;  // one spare bit so out-of-range columns can be driven
  localparam int YW   = 3;
  localparam int LW   = 4;
  localparam int CW   = 8;
  localparam int NPIX = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst;
  logic          lvl_we;
  logic [XW-1:0] lvl_col;
  logic [LW-1:0] lvl_val;
  logic [1:0]    mode;
  logic          start;
  logic          busy, frame_done, valid, flip, flipped;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] red, green, blue;

  bar_frame_gen #(.COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .lvl_we(lvl_we), .lvl_col(lvl_col), .lvl_val(lvl_val),
    .mode(mode), .start(start), .busy(busy), .frame_done(frame_done), .x(x), .y(y),
    .red(red), .green(green), .blue(blue), .valid(valid), .flip(flip), .flipped(flipped)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_flip;
    logic [31:0] pix;  // {x, y, red, green, blue}
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   ref_lvl [COLS];
  int   cyc = 0;
  int   flips = 0;
  int   flip_cyc = 0;
  int   run = 0;
  int   start_cyc = 0;
  int   flips_before = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference colour: a bar of height lvl, lower half green, next quarter yellow,
  // top quarter red; peak mode lights only the top pixel of the bar in white.
  function automatic logic [23:0] model_rgb(input int lvl, input int row, input int m);
    if (m == 1) return (lvl >= 1 && row + 1 == lvl) ? 24'hFFFFFF : 24'h000000;
    if (row >= lvl) return 24'h000000;
    if (4 * row < 2 * ROWS) return 24'h00FF00;
    if (4 * row < 3 * ROWS) return 24'hFFFF00;
    return 24'hFF0000;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      run++;
      if (sb.size() == 0) begin
        check("unexpected_pixel", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pixel_not_flip", 64'(mon_e.is_flip), 0);
        check("pixel", {x, y, red, green, blue}, mon_e.pix);
      end
    end else begin
      if (flip) begin
        flips++;
        flip_cyc = cyc;
        check("flip_expected", 64'(sb.size() > 0 && sb[0].is_flip), 1);
        if (sb.size() > 0 && sb[0].is_flip) void'(sb.pop_front());
        check("valid_run_len", run, NPIX);
      end
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int col, input int val);
    if (col < COLS) ref_lvl[col] = (val > ROWS) ? ROWS : val;
  endtask

  task automatic wr(input int col, input int val);
    lvl_we  = 1'b1;
    lvl_col = XW'(col);
    lvl_val = LW'(val);
    tick();
    lvl_we  = 1'b0;
    model_write(col, val);
  endtask

  task automatic push_frame(input int m);
    int em;
    exp_t e;
    em = (m == 1) ? 1 : 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        e.is_flip = 1'b0;
        e.pix     = {5'(c), 3'(r), model_rgb(ref_lvl[c], r, em)};
        sb.push_back(e);
      end
    end
    e.is_flip = 1'b1;
    e.pix     = '0;
    sb.push_back(e);
  endtask

  task automatic start_frame(input int m, input bit with_wr, input int col, input int val);
    start = 1'b1;
    mode  = 2'(m);
    if (with_wr) begin
      lvl_we  = 1'b1;
      lvl_col = XW'(col);
      lvl_val = LW'(val);
      model_write(col, val);
    end
    push_frame(m);
    flips_before = flips;
    tick();
    start_cyc = cyc;
    start     = 1'b0;
    lvl_we    = 1'b0;
  endtask

  task automatic wait_flip();
    for (int i = 0; i < 400 && flips == flips_before; i++) tick();
    check("flip_seen", 64'(flips != flips_before), 1);
    check("flip_latency", flip_cyc - start_cyc + 1, NPIX + 1);
  endtask

  task automatic finish_frame(input int hold);
    bit all_busy;
    int f0;
    all_busy = 1'b1;
    f0 = flips;
    repeat (hold) begin
      if (!busy) all_busy = 1'b0;
      tick();
    end
    check("busy_in_wait", 64'(all_busy), 1);
    check("single_flip", flips, f0);
    flipped = 1'b1;
    tick();
    flipped = 1'b0;
    check("frame_done_high", 64'(frame_done), 1);
    check("busy_after_ack", 64'(busy), 0);
    tick();
    check("frame_done_pulse", 64'(frame_done), 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < COLS; i++) ref_lvl[i] = 0;
    rst = 1'b1; lvl_we = 1'b0; lvl_col = '0; lvl_val = '0;
    mode = 2'd0; start = 1'b0; flipped = 1'b0;
    #2;
    check("reset_outputs", {x, y, red, green, blue, valid, flip, busy, frame_done}, 0);
    #20;
    rst = 1'b0;
    tick();

    // 1: blank frame, long wait for acknowledge
    start_frame(0, 1'b0, 0, 0);
    wait_flip();
    finish_frame(10);

    // 2: gradient bars with clamping
    wr(2, 3); wr(5, 8); wr(9, 12);
    start_frame(0, 1'b0, 0, 0);
    wait_flip();
    finish_frame(2);

    // 3: peak dot, then an empty peak column
    wr(2, 0); wr(5, 0); wr(9, 0); wr(4, 5);
    start_frame(1, 1'b0, 0, 0);
    wait_flip();
    finish_frame(2);
    wr(4, 0);
    start_frame(1, 1'b0, 0, 0);
    wait_flip();
    finish_frame(2);

    // 4: writes during render land in the next frame; out-of-range column ignored
    wr(3, 2);
    start_frame(0, 1'b0, 0, 0);
    wr(3, 7);
    wr(20, 6);
    wait_flip();
    finish_frame(2);
    start_frame(2, 1'b1, 7, 6);
    wait_flip();
    finish_frame(2);

    // 5: start and flipped during render are ignored
    start_frame(3, 1'b0, 0, 0);
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    flipped = 1'b1; tick(); flipped = 1'b0;
    wait_flip();
    finish_frame(6);

    // 6: asynchronous reset mid-frame
    wr(1, 8);
    start_frame(0, 1'b0, 0, 0);
    repeat (20) tick();
    #3;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < COLS; i++) ref_lvl[i] = 0;
    #1;
    check("rst_valid_low", 64'(valid), 0);
    check("rst_busy_low", 64'(busy), 0);
    check("rst_pixel_clear", {x, y, red, green, blue}, 0);
    #12;
    rst = 1'b0;
    flips_before = flips;
    repeat (4) tick();
    check("no_flip_after_rst", flips, flips_before);
    start_frame(0, 1'b0, 0, 0);
    wait_flip();
    finish_frame(2);

    // randomized frames
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(2, 8)) wr($urandom_range(0, COLS + 3), $urandom_range(0, 15));
      start_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, COLS + 3), $urandom_range(0, 15));
      repeat (3) wr($urandom_range(0, COLS - 1), $urandom_range(0, 15));
      wait_flip();
      finish_frame($urandom_range(1, 5));
    end

    check("sb_empty_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bar_frame_gen.md
Name: bar_frame_gen

Overview:
- Parametrised frame generator for the LED matrix visualiser; successor to the fixed 16x8, three-fixed-column pattern generator.
- Holds one bar level per column in a double-buffered register file, renders a full frame of bars into the led_display pixel-write interface, then performs the flip handshake.
- Supports two render modes: solid gradient bars and peak dot.
- Sits between the level source (e.g. FFT band magnitudes) and led_display.

Parameters:
- COLS, 16, matrix columns (x range 0..COLS-1).
- ROWS, 8, matrix rows (y range 0..ROWS-1; y=0 is the bottom row).
- XW, 4, width of x and lvl_col; must be >= clog2(COLS).
- YW, 3, width of y; must be >= clog2(ROWS).
- LW, 4, level width; must hold the value ROWS.
- CW, 8, per-channel colour width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- lvl_we  in  1  level write strobe.
- lvl_col  in  XW  column index to write.
- lvl_val  in  LW  bar height in lit pixels.
- mode  in  2  0 = solid gradient bars, 1 = peak dot, 2/3 = treated as 0.
- start  in  1  request one frame render.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- x  out  XW  pixel column.
- y  out  YW  pixel row.
- red  out  CW  pixel red value.
- green  out  CW  pixel green value.
- blue  out  CW  pixel blue value.
- valid  out  1  pixel write strobe.
- flip  out  1  one-cycle buffer-flip request to the display.
- flipped  in  1  display acknowledge of flip.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All pending and active levels = 0; latched mode = 0.
  - Outputs x, y, red, green, blue, valid, flip, busy, frame_done = 0.
  - Reset mid-frame abandons the frame; no flip is issued.
- Level writes:
  - On lvl_we, pending[lvl_col] <= min(lvl_val, ROWS).
  - Writes with lvl_col >= COLS are ignored.
  - Writes are accepted in every state and never disturb the frame in progress.
- States and transitions:
  - IDLE -> RENDER on start.
    - Copies pending to active in one cycle and latches mode.
    - A lvl_we in the same cycle as start is included in the snapshot (write-through).
    - start is ignored while busy.
  - RENDER:
    - Emits one pixel per cycle, all outputs registered.
    - Pixel (0,0) appears with valid=1 in the first cycle after start is sampled.
    - Scan order: x increments 0..COLS-1 (inner loop), then y increments 0..ROWS-1.
    - Gives exactly COLS*ROWS consecutive valid cycles.
    - After the pixel (COLS-1, ROWS-1) cycle, goes to FLIP.
  - FLIP: valid=0, flip=1 for exactly one cycle, then WAIT_FLIP.
  - WAIT_FLIP:
    - valid=0, flip=0.
    - On flipped=1: pulse frame_done for one cycle and return to IDLE.
    - flipped is only sampled in this state; flipped pulses in any other state are ignored.
  - Latency: from start sampled to flip asserted is COLS*ROWS+1 cycles.
- Pixel colour, with L = active[x]:
  - Mode 0, pixel lit iff y < L:
    - y < ROWS/2: green = max.
    - ROWS/2 <= y < 3*ROWS/4: red = green = max.
    - y >= 3*ROWS/4: red = max.
  - Mode 1: pixel lit iff L > 0 and y == L-1; colour is red = green = blue = max.
  - Unlit pixels are still written (valid=1) with all channels 0, so stale bars clear.
- Counters:
  - x and y wrap to 0 at their end values.
  - They never index beyond COLS-1 or ROWS-1 for non-power-of-two sizes.

Test Plan:
1. Reset, then start with all levels 0: 128 valid cycles, all rgb=0, then flip=1 on cycle 129. Hold flipped=0 for 10 cycles: busy stays 1. Pulse flipped: frame_done=1 for one cycle, busy=0.
2. Write col2=3, col5=8, col9=12, then start in mode 0:
   - col2 rows 0-2 green.
   - col5 rows 0-3 green, rows 4-5 red+green, rows 6-7 red.
   - col9 is clamped to 8, so rendered identical to col5.
   - All other pixels 0.
3. Mode 1 with col4=5: only pixel (4,4) is white; col4=0 yields no lit pixel in that column.
4. Write col3=7 during RENDER: the current frame still shows the old col3; the next frame shows height 7. lvl_col=20 is ignored. A lvl_we on the same cycle as start is reflected in that frame.
5. Pulse start while busy, and pulse flipped during RENDER: both are ignored. Exactly one flip is issued per frame, and the state machine still waits for a flipped pulse in WAIT_FLIP.
6. Assert rst asynchronously mid-RENDER (not on a clock edge): valid and busy drop to 0 immediately. After release, all levels are 0 and a new start renders a blank frame.
